telem_pkt_parser: RTL
=====================

Name: telem_pkt_parser

Overview:
- Downstream consumer of the eBike telemetry UART stream.
- Sits after UART_rcv, in the bench and in any board-side monitor.
- Consumes received bytes through UART_rcv's rdy/clr_rdy handshake and locates the 0xAA,0x55 packet header.
- Reassembles the 12-bit BATT, CURR and TORQUE fields, then presents them as registered values with a one-cycle valid strobe and packet/error counters.

Parameters:
TIMEOUT_CYC, 65536, max clk cycles allowed between accepted bytes inside a packet before the partial packet is aborted (counter width = $clog2(TIMEOUT_CYC)+1)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock; reset is synchronous and active-low
rx_rdy  input  1  UART_rcv rdy: byte available on rx_data
rx_data  input  8  UART_rcv received byte
clr_rdy  output  1  registered one-cycle pulse to UART_rcv clr_rdy acknowledging a byte
batt  output  12  last valid battery reading
curr  output  12  last valid current reading
torque  output  12  last valid torque reading
pkt_vld  output  1  one-cycle pulse; batt/curr/torque just updated
pkt_cnt  output  16  count of valid packets, wraps 0xFFFF->0
err_cnt  output  8  count of framing errors, saturates at 0xFF
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low at posedge): state=IDLE; clr_rdy=0, batt=curr=torque=0, pkt_vld=0, pkt_cnt=0, err_cnt=0, byte index=0, timeout counter=0.
- Byte accept: a byte is accepted on a posedge where rx_rdy=1 and clr_rdy=0.
  - clr_rdy is 1 exactly in the cycle after acceptance.
  - rx_rdy still high during that clr_rdy cycle is ignored, so there is no double accept.
- Packet format: 0xAA, 0x55, {4'h0,BATT[11:8]}, BATT[7:0], {4'h0,CURR[11:8]}, CURR[7:0], {4'h0,TORQUE[11:8]}, TORQUE[7:0].
- States:
  - IDLE: accepted 0xAA -> HDR2. Any other byte is discarded silently, with no error.
  - HDR2:
    - 0x55 -> PAYLOAD with idx=0.
    - 0xAA -> stay in HDR2 (resync), no error.
    - Other byte -> err, IDLE.
  - PAYLOAD: each accepted byte is stored into a shadow register at idx, then idx increments.
    - Byte at even idx (high byte) with upper nibble != 0 -> err, IDLE. The shadow contents are discarded.
    - Byte at idx=5 accepted -> commit, IDLE.
- Commit: at the acceptance edge, batt/curr/torque load the shadow values and the final byte. In the following cycle:
  - pkt_vld=1 for exactly one cycle;
  - pkt_cnt has incremented.
- err: err_cnt increments by 1 (saturating at 0xFF). Outputs batt/curr/torque are unchanged and pkt_vld stays 0.
- Timeout:
  - In HDR2 or PAYLOAD, the counter increments every cycle with no accept and clears on each accept.
  - Reaching TIMEOUT_CYC-1 -> err, IDLE.
  - The counter is held at 0 in IDLE.
- Simultaneous events: if an accept and a timeout occur on the same edge, the accept wins and the counter clears.
- Reset mid-packet: the partial packet is dropped, the counters clear, and no pkt_vld is issued.
- busy follows state combinationally: 0 only in IDLE.

Optional Feature:
- Macro: TELEM_CKSUM_EN
- Defined:
  - Packet carries a 9th byte: the 8-bit sum mod 256 of the six payload bytes.
  - PAYLOAD runs to idx=6.
  - Commit happens only if the checksum matches; a mismatch -> err, IDLE, outputs unchanged.
- Undefined: 8-byte packet; no checksum logic is synthesized.

Test Plan:
- Reset then send AA 55 0B 80 01 23 07 00 -> one pkt_vld pulse; batt=0xB80, curr=0x123, torque=0x700; pkt_cnt=1, err_cnt=0.
- Send 12 34 AA AA 55 followed by a valid payload (0B 80 01 23 05 00) -> the leading junk is ignored silently and the AA AA resync works; torque=0x500, err_cnt=0.
- Send AA 55 1B ... (high nibble set) -> err_cnt=1, no pkt_vld, outputs retain their prior values, and the next good packet is parsed.
- Send AA 55 0B 80, then idle for TIMEOUT_CYC cycles -> err_cnt increments and busy returns to 0. A subsequent good packet commits.
- Hold rx_rdy high for 2 cycles per byte (UART_rcv timing) over 3 back-to-back packets -> clr_rdy pulses once per byte, no double accept, pkt_cnt=3.
- Assert rst_n low mid-payload -> all outputs return to 0 on the next edge with no pkt_vld. With TELEM_CKSUM_EN defined, a wrong 9th byte -> err_cnt=1 and no commit.

Source files
------------

// File: rtl/telem_pkt_parser.sv
// Telemetry packet parser: finds the 0xAA,0x55 header in the UART_rcv byte stream and
// reassembles BATT/CURR/TORQUE. Define TELEM_CKSUM_EN for the 9-byte checksummed packet.
module telem_pkt_parser #(
    parameter int TIMEOUT_CYC = 65536
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rdy,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] torque,
    output logic        pkt_vld,
    output logic [15:0] pkt_cnt,
    output logic [7:0]  err_cnt,
    output logic        busy,
    output logic [1:0]  dbg_state
);
    localparam int            TW       = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
`ifdef TELEM_CKSUM_EN
    localparam logic [2:0]    LAST_IDX = 3'd6;
`else
    localparam logic [2:0]    LAST_IDX = 3'd5;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HDR2    = 2'd1,
        S_PAYLOAD = 2'd2
    } state_t;

    state_t        r_state;
    logic [2:0]    r_idx;
    logic [TW-1:0] r_tmo;
    logic [3:0]    r_b_hi, r_c_hi, r_t_hi;
    logic [7:0]    r_b_lo, r_c_lo;
`ifdef TELEM_CKSUM_EN
    logic [7:0]    r_t_lo, r_sum;
`endif

    logic w_accept, w_timeout, w_last, w_hi_bad, w_cksum_ok, w_commit, w_err;

    // Handshake: a byte is taken when rx_rdy is high and no acknowledge is in flight;
    // clr_rdy is the one-cycle acknowledge, so rx_rdy lingering during it is not re-taken.
    assign w_accept  = rx_rdy & ~clr_rdy;
    assign w_timeout = (r_state != S_IDLE) && (r_tmo == TMO_LAST);
    assign w_last    = (r_idx == LAST_IDX);
    // High bytes sit at even idx below the checksum slot
    assign w_hi_bad  = ~r_idx[0] && (r_idx < 3'd6) && (rx_data[7:4] != 4'h0);
`ifdef TELEM_CKSUM_EN
    assign w_cksum_ok = (rx_data == r_sum);
`else
    assign w_cksum_ok = 1'b1;
`endif
    assign w_commit  = w_accept && (r_state == S_PAYLOAD) && w_last && !w_hi_bad && w_cksum_ok;

    always_comb begin
        w_err = 1'b0;
        if (w_accept) begin
            case (r_state)
                S_HDR2:    w_err = (rx_data != 8'h55) && (rx_data != 8'hAA);
                S_PAYLOAD: w_err = w_hi_bad || (w_last && !w_cksum_ok);
                default:   w_err = 1'b0;
            endcase
        end else begin
            w_err = w_timeout;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= 3'd0;
            r_tmo   <= '0;
            r_b_hi  <= 4'h0;
            r_c_hi  <= 4'h0;
            r_t_hi  <= 4'h0;
            r_b_lo  <= 8'h00;
            r_c_lo  <= 8'h00;
`ifdef TELEM_CKSUM_EN
            r_t_lo  <= 8'h00;
            r_sum   <= 8'h00;
`endif
            clr_rdy <= 1'b0;
            pkt_vld <= 1'b0;
            batt    <= 12'h000;
            curr    <= 12'h000;
            torque  <= 12'h000;
            pkt_cnt <= 16'h0000;
            err_cnt <= 8'h00;
        end else begin
            clr_rdy <= w_accept;
            pkt_vld <= w_commit;
            if (w_err && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
            if (w_commit) begin
                pkt_cnt <= pkt_cnt + 16'd1;
                batt    <= {r_b_hi, r_b_lo};
                curr    <= {r_c_hi, r_c_lo};
`ifdef TELEM_CKSUM_EN
                torque  <= {r_t_hi, r_t_lo};
`else
                torque  <= {r_t_hi, rx_data};
`endif
            end

            if ((r_state == S_IDLE) || w_accept || w_timeout)
                r_tmo <= '0;
            else
                r_tmo <= r_tmo + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_accept && (rx_data == 8'hAA))
                        r_state <= S_HDR2;
                end
                S_HDR2: begin
                    if (w_accept) begin
                        if (rx_data == 8'h55) begin
                            r_state <= S_PAYLOAD;
                            r_idx   <= 3'd0;
                        end else if (rx_data != 8'hAA) begin
                            r_state <= S_IDLE;
                        end
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                S_PAYLOAD: begin
                    if (w_accept) begin
                        if (w_hi_bad || w_last) begin
                            r_state <= S_IDLE;
                            r_idx   <= 3'd0;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                        end
                        case (r_idx)
                            3'd0:    r_b_hi <= rx_data[3:0];
                            3'd1:    r_b_lo <= rx_data;
                            3'd2:    r_c_hi <= rx_data[3:0];
                            3'd3:    r_c_lo <= rx_data;
                            3'd4:    r_t_hi <= rx_data[3:0];
`ifdef TELEM_CKSUM_EN
                            3'd5:    r_t_lo <= rx_data;
`endif
                            default: ;
                        endcase
`ifdef TELEM_CKSUM_EN
                        r_sum <= (r_idx == 3'd0) ? rx_data : (r_sum + rx_data);
`endif
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                        r_idx   <= 3'd0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

endmodule
